// File: rtl/steer_en_sm.sv
// Rider-presence and balance FSM: watches the left/right load cells and enables
// steering once a rider has stood balanced for a full balance-timer period.
module steer_en_sm #(
    parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
    parameter logic [11:0] WT_HYSTERESIS = 12'h040,
    parameter bit          FAST_SIM      = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam int TMR_W = FAST_SIM ? 15 : 26;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STEER_EN
    } state_t;

    state_t             state;
    state_t             nxt_state;
    logic [TMR_W-1:0]   tmr;
    logic [TMR_W-1:0]   tmr_nxt;
    logic               tmr_full;

    logic [12:0]        sum;
    logic [11:0]        diff;
    logic [16:0]        sum_x15;
    logic               sum_gt_min;
    logic               sum_lt_min;
    logic               diff_gt_1_4;
    logic               diff_gt_15_16;

    // Thresholds are compared at 14 bits with the hysteresis moved to the sum
    // side of the low compare, so a small MIN_RIDER_WT can never wrap.
    always_comb begin
        sum           = {1'b0, lft_ld} + {1'b0, rght_ld};
        diff          = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
        sum_x15       = ({4'b0000, sum} << 4) - {4'b0000, sum};
        sum_gt_min    = {1'b0, sum} > ({2'b00, MIN_RIDER_WT} + {2'b00, WT_HYSTERESIS});
        sum_lt_min    = ({1'b0, sum} + {2'b00, WT_HYSTERESIS}) < {2'b00, MIN_RIDER_WT};
        diff_gt_1_4   = {diff, 2'b00} > {1'b0, sum};
        diff_gt_15_16 = {1'b0, diff, 4'b0000} > sum_x15;
        tmr_full      = &tmr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tmr   <= '0;
        end else begin
            state <= nxt_state;
            tmr   <= tmr_nxt;
        end
    end

    always_comb begin
        nxt_state = state;
        tmr_nxt   = '0;

        // The timer only runs in WAIT while the rider is balanced; it is
        // dropped back to zero at full count since WAIT is being left anyway.
        if ((state == WAIT) && !diff_gt_1_4 && !tmr_full) begin
            tmr_nxt = tmr + TMR_W'(1);
        end

        case (state)
            IDLE: begin
                if (sum_gt_min) begin
                    nxt_state = WAIT;
                end
            end
            WAIT: begin
                if (sum_lt_min) begin
                    nxt_state = IDLE;
                end else if (diff_gt_1_4) begin
                    nxt_state = WAIT;
                end else if (tmr_full) begin
                    nxt_state = STEER_EN;
                end
            end
            STEER_EN: begin
                if (sum_lt_min) begin
                    nxt_state = IDLE;
                end else if (diff_gt_15_16) begin
                    nxt_state = WAIT;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    assign en_steer  = (state == STEER_EN);
    assign rider_off = (state == IDLE);

endmodule

// File: tb/tb_steer_en_sm.sv
// Randomized bench for steer_en_sm (FAST_SIM) against a rider/balance model
// expressed directly in load sums and differences.
module tb_steer_en_sm;

    localparam int FULL_COUNT = 32768;
    localparam int SUM_ON     = 576;
    localparam int SUM_OFF    = 448;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    int vectors     = 0;
    int miscompares = 0;

    steer_en_sm #(
        .MIN_RIDER_WT (12'h200),
        .WT_HYSTERESIS(12'h040),
        .FAST_SIM     (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .en_steer (en_steer),
        .rider_off(rider_off)
    );

    always #5 clk = ~clk;

    // Model: a rider is "on" once the sum clears the upper band edge and "off"
    // once it drops below the lower one; steering needs FULL_COUNT balanced
    // samples in a row after the rider boards or after any imbalance.
    bit mdlOn    = 1'b0;
    bit mdlSteer = 1'b0;
    int mdlRun   = 0;
    int mdlSum;
    int mdlDiff;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdlOn    = 1'b0;
            mdlSteer = 1'b0;
            mdlRun   = 0;
        end else begin
            mdlSum  = int'(lft_ld) + int'(rght_ld);
            mdlDiff = int'(lft_ld) - int'(rght_ld);
            if (mdlDiff < 0) mdlDiff = -mdlDiff;
            if (!mdlOn) begin
                if (mdlSum > SUM_ON) begin
                    mdlOn  = 1'b1;
                    mdlRun = 0;
                end
            end else if (mdlSum < SUM_OFF) begin
                mdlOn    = 1'b0;
                mdlSteer = 1'b0;
            end else if (mdlSteer) begin
                if (16 * mdlDiff > 15 * mdlSum) begin
                    mdlSteer = 1'b0;
                    mdlRun   = 0;
                end
            end else if (4 * mdlDiff > mdlSum) begin
                mdlRun = 0;
            end else if (mdlRun == FULL_COUNT - 1) begin
                mdlSteer = 1'b1;
            end else begin
                mdlRun = mdlRun + 1;
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (en_steer !== mdlSteer || rider_off !== !mdlOn) begin
            miscompares++;
            $display("[TB] FAIL cycle_model t=%0t: en_steer=%b rider_off=%b, expected en_steer=%b rider_off=%b",
                     $time, en_steer, rider_off, mdlSteer, !mdlOn);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
        tick();
    endtask

    task automatic applyBalanced();
        applyStimulus(12'h150 + 12'($urandom_range(0, 31)), 12'h150 + 12'($urandom_range(0, 31)));
    endtask

    task automatic checkOutput(input string name, input logic expEn, input logic expOff);
        vectors++;
        if (en_steer !== expEn || rider_off !== expOff) begin
            miscompares++;
            $display("[TB] FAIL %s: en_steer=%b rider_off=%b, expected en_steer=%b rider_off=%b",
                     name, en_steer, rider_off, expEn, expOff);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: took %0d cycles, expected %0d", name, got, exp);
        end
    endtask

    // Counts edges from the given first sample until en_steer rises, bounded.
    task automatic countUntilSteer(input logic [11:0] l, input logic [11:0] r, output int n);
        applyStimulus(l, r);
        n = 1;
        while (!en_steer && n < FULL_COUNT + 8000) begin
            applyBalanced();
            n++;
        end
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        lft_ld  = 12'($urandom_range(0, 4095));
        rght_ld = 12'($urandom_range(0, 4095));
        repeat (3) tick();
        checkOutput("reset_hold", 1'b0, 1'b1);
        lft_ld  = 12'h000;
        rght_ld = 12'h000;
        rst_n   = 1'b1;
        applyStimulus(12'h000, 12'h000);
        checkOutput("post_reset", 1'b0, 1'b1);

        applyStimulus(12'h120, 12'h120);
        checkOutput("idle_band_top", 1'b0, 1'b1);
        applyStimulus(12'h150, 12'h150);
        checkOutput("enter_wait", 1'b0, 1'b0);
        repeat (300) applyBalanced();

        lft_ld  = 12'h150;
        rght_ld = 12'h150;
        rst_n   = 1'b0;
        #1;
        checkOutput("reset_async", 1'b0, 1'b1);
        tick();
        checkOutput("reset_held", 1'b0, 1'b1);
        rst_n = 1'b1;
        applyStimulus(12'h150, 12'h150);
        checkOutput("reenter_wait", 1'b0, 1'b0);
        countUntilSteer(12'h150, 12'h150, n);
        checkCount("wait_to_steer", n, FULL_COUNT);
        checkOutput("steer_on", 1'b1, 1'b0);

        applyStimulus(12'h1A0, 12'h100);
        checkOutput("mild_imbalance", 1'b1, 1'b0);
        applyStimulus(12'h100, 12'h100);
        checkOutput("steer_in_band", 1'b1, 1'b0);
        applyStimulus(12'h0E0, 12'h0E0);
        checkOutput("steer_band_low", 1'b1, 1'b0);
        applyStimulus(12'h0D8, 12'h0D8);
        checkOutput("steer_drop", 1'b0, 1'b1);

        applyStimulus(12'h150, 12'h150);
        checkOutput("wait_again", 1'b0, 1'b0);
        repeat (1000) applyBalanced();
        repeat (5) applyStimulus(12'h200, 12'h0A0);
        checkOutput("imbalance_hold", 1'b0, 1'b0);
        countUntilSteer(12'h150, 12'h150, n);
        checkCount("restore_to_steer", n, FULL_COUNT);
        checkOutput("steer_again", 1'b1, 1'b0);

        applyStimulus(12'd620, 12'd20);
        checkOutput("severe_edge", 1'b1, 1'b0);
        applyStimulus(12'h290, 12'h010);
        checkOutput("severe_imbalance", 1'b0, 1'b0);
        applyStimulus(12'h1B0, 12'h000);
        checkOutput("low_beats_imbalance", 1'b0, 1'b1);
        applyStimulus(12'h121, 12'h120);
        checkOutput("idle_exit_edge", 1'b0, 1'b0);
        applyStimulus(12'h0E0, 12'h0E0);
        checkOutput("wait_band_low", 1'b0, 1'b0);
        applyStimulus(12'h0E0, 12'h0DF);
        checkOutput("wait_exit_edge", 1'b0, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            logic [11:0] l;
            logic [11:0] r;
            case ($urandom_range(0, 3))
                0: begin
                    l = 12'($urandom_range(0, 4095));
                    r = 12'($urandom_range(0, 4095));
                end
                1: begin
                    l = 12'($urandom_range(12'h0C0, 12'h140));
                    r = 12'($urandom_range(12'h0C0, 12'h140));
                end
                2: begin
                    l = 12'h150 + 12'($urandom_range(0, 31));
                    r = 12'h150 + 12'($urandom_range(0, 31));
                end
                default: begin
                    l = 12'($urandom_range(12'h180, 12'h300));
                    r = 12'($urandom_range(0, 12'h080));
                end
            endcase
            repeat ($urandom_range(1, 8)) applyStimulus(l, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
